// File: rtl/wb_bus_arbiter.sv
// Shares one Wishbone master port between instruction fetch (IF) and data access (MEM).
// Results that arrive while the owning stage is stalled are held in a per-port buffer.
module wb_bus_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        stallreq_if,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq_mem,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DBUS  = 2'd1,
        S_IBUS  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [7:0]    to_q, to_d;
    logic          bus_err_q, bus_err_d;
    logic          if_vld_q, if_vld_d;
    logic [31:0]   if_buf_q, if_buf_d;
    logic          mem_vld_q, mem_vld_d;
    logic [31:0]   mem_buf_q, mem_buf_d;

    logic          busy, bus_ack, tmo, fin, if_fin, mem_fin;
    logic [31:0]   fin_data;
    logic          if_req, mem_req, grant_if, grant_mem;
    logic          unused_stall;

    assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

    always_comb begin
        busy      = (state_q != S_IDLE);
        bus_ack   = busy & wb_ack_i;
        // A timed-out cycle ends like an ack that returned zero.
        tmo       = busy & ~wb_ack_i & (to_q == TO_LAST);
        fin       = bus_ack | tmo;
        if_fin    = (state_q == S_IBUS) & fin;
        mem_fin   = (state_q == S_DBUS) & fin;
        fin_data  = bus_ack ? wb_dat_i : 32'h0;

        if_req    = if_ce & ~if_vld_q;
        mem_req   = mem_ce & ~mem_vld_q;
        grant_if  = ~busy & ~flush & if_req & (~mem_req | (if_ce & (starve_q == STARVE_TOP)));
        grant_mem = ~busy & ~flush & mem_req & ~grant_if;

        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        starve_d  = starve_q;
        to_d      = 8'h0;
        bus_err_d = tmo;

        case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    state_d = S_DBUS;
                    cyc_d   = 1'b1;
                    we_d    = mem_we;
                    sel_d   = mem_sel;
                    adr_d   = mem_addr;
                    dat_d   = mem_wdata;
                    if (if_ce && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (grant_if) begin
                    state_d  = S_IBUS;
                    cyc_d    = 1'b1;
                    we_d     = 1'b0;
                    sel_d    = 4'hF;
                    adr_d    = if_addr;
                    dat_d    = 32'h0;
                    starve_d = '0;
                end
            end
            default: begin
                if (fin) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    to_d = to_q + 8'd1;
                    // The slave still owes an ack, so a flush only retires the owner.
                    if (flush) begin
                        state_d = S_DRAIN;
                    end
                end
            end
        endcase

        if_vld_d  = if_vld_q & stall[1];
        if_buf_d  = if_buf_q;
        if (if_fin && stall[1]) begin
            if_vld_d = 1'b1;
            if_buf_d = fin_data;
        end
        mem_vld_d = mem_vld_q & stall[4];
        mem_buf_d = mem_buf_q;
        if (mem_fin && stall[4]) begin
            mem_vld_d = 1'b1;
            mem_buf_d = fin_data;
        end
        if (flush) begin
            if_vld_d  = 1'b0;
            mem_vld_d = 1'b0;
            starve_d  = '0;
        end

        if_rdata     = if_fin ? fin_data : if_buf_q;
        mem_rdata    = mem_fin ? fin_data : mem_buf_q;
        stallreq_if  = if_ce & ~(if_fin | if_vld_q);
        stallreq_mem = mem_ce & ~(mem_fin | mem_vld_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            starve_q  <= '0;
            to_q      <= 8'h0;
            bus_err_q <= 1'b0;
            if_vld_q  <= 1'b0;
            if_buf_q  <= 32'h0;
            mem_vld_q <= 1'b0;
            mem_buf_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            starve_q  <= starve_d;
            to_q      <= to_d;
            bus_err_q <= bus_err_d;
            if_vld_q  <= if_vld_d;
            if_buf_q  <= if_buf_d;
            mem_vld_q <= mem_vld_d;
            mem_buf_q <= mem_buf_d;
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign bus_err_o   = bus_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for starvation, timeout and mid-cycle reset.
module tb_wb_bus_arbiter;

    localparam logic [3:0]  MEM_SEL   = 4'h3;
    localparam logic [31:0] MEM_WDATA = 32'h5555AAAA;
    localparam logic [5:0]  S0   = 6'b000000;
    localparam logic [5:0]  SIF  = 6'b000010;
    localparam logic [5:0]  SMEM = 6'b010000;
    localparam int          TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        stallreq_if;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = MEM_SEL;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = MEM_WDATA;
    logic [31:0] mem_rdata;
    logic        stallreq_mem;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;

    int n_chk = 0;
    int n_err = 0;

    wb_bus_arbiter #(.STARVE_MAX(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata), .stallreq_if(stallreq_if),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .bus_err_o(bus_err_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ctl = {flush, if_ce, mem_ce, mem_we, ack}; ex = {cyc, we, stallreq_if, stallreq_mem}
    // rc: 0 = no rdata check, 1 = check if_rdata, 2 = check mem_rdata
    typedef struct {
        logic [5:0]  stall;
        logic [4:0]  ctl;
        logic [31:0] ia;
        logic [31:0] ma;
        logic [31:0] dat;
        logic [3:0]  ex;
        logic [3:0]  esel;
        logic [31:0] eadr;
        logic [1:0]  rc;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    function automatic vec_t mk(input logic [5:0] st, input logic [4:0] c, input logic [31:0] ia,
                                input logic [31:0] ma, input logic [31:0] d, input logic [3:0] ex,
                                input logic [3:0] es, input logic [31:0] ea, input logic [1:0] rc,
                                input logic [31:0] er);
        vec_t v;
        v.stall = st; v.ctl = c; v.ia = ia; v.ma = ma; v.dat = d;
        v.ex = ex; v.esel = es; v.eadr = ea; v.rc = rc; v.erd = er;
        return v;
    endfunction

    // driver / checker tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        stall    = v.stall;
        flush    = v.ctl[4];
        if_ce    = v.ctl[3];
        mem_ce   = v.ctl[2];
        mem_we   = v.ctl[1];
        wb_ack_i = v.ctl[0];
        if_addr  = v.ia;
        mem_addr = v.ma;
        wb_dat_i = v.dat;
        #1;
    endtask

    initial begin
        int grants;
        int cycles;
        int cnt;
        logic seen_end;

        // Load with two wait cycles
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h100, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h100, 32'h0,        4'b1001, 4'h3, 32'h100, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h100, 32'h0,        4'b1001, 4'h3, 32'h100, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00101, 32'h0, 32'h100, 32'hDEADBEEF, 4'b1000, 4'h3, 32'h100, 2'd2, 32'hDEADBEEF));
        vecs.push_back(mk(S0, 5'b00000, 32'h0, 32'h100, 32'h0,        4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Both requesters: data first, fetch after one idle cycle
        vecs.push_back(mk(S0, 5'b01100, 32'h200, 32'h300, 32'h0,      4'b0011, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b01100, 32'h200, 32'h300, 32'h0,      4'b1011, 4'h3, 32'h300, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b01101, 32'h200, 32'h300, 32'h11112222, 4'b1010, 4'h3, 32'h300, 2'd2, 32'h11112222));
        vecs.push_back(mk(S0, 5'b01000, 32'h200, 32'h300, 32'h0,      4'b0010, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b01000, 32'h200, 32'h300, 32'h0,      4'b1010, 4'hF, 32'h200, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b01001, 32'h200, 32'h300, 32'h33334444, 4'b1000, 4'hF, 32'h200, 2'd1, 32'h33334444));
        vecs.push_back(mk(S0, 5'b00000, 32'h0, 32'h0, 32'h0,          4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Fetch ack under stall[1]: buffered until the stall falls
        vecs.push_back(mk(SIF, 5'b01000, 32'h204, 32'h0, 32'h0,        4'b0010, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(SIF, 5'b01000, 32'h204, 32'h0, 32'h0,        4'b1010, 4'hF, 32'h204, 2'd0, 32'h0));
        vecs.push_back(mk(SIF, 5'b01001, 32'h204, 32'h0, 32'h24020001, 4'b1000, 4'hF, 32'h204, 2'd1, 32'h24020001));
        vecs.push_back(mk(SIF, 5'b01000, 32'h204, 32'h0, 32'hBAD0BAD0, 4'b0000, 4'h0, 32'h0,   2'd1, 32'h24020001));
        vecs.push_back(mk(S0,  5'b01000, 32'h204, 32'h0, 32'hBAD0BAD0, 4'b0000, 4'h0, 32'h0,   2'd1, 32'h24020001));
        vecs.push_back(mk(S0,  5'b00000, 32'h0, 32'h0, 32'h0,          4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Load ack under stall[4]
        vecs.push_back(mk(SMEM, 5'b00100, 32'h0, 32'h400, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(SMEM, 5'b00100, 32'h0, 32'h400, 32'h0,        4'b1001, 4'h3, 32'h400, 2'd0, 32'h0));
        vecs.push_back(mk(SMEM, 5'b00101, 32'h0, 32'h400, 32'hCAFEF00D, 4'b1000, 4'h3, 32'h400, 2'd2, 32'hCAFEF00D));
        vecs.push_back(mk(SMEM, 5'b00100, 32'h0, 32'h400, 32'h12345678, 4'b0000, 4'h0, 32'h0,   2'd2, 32'hCAFEF00D));
        vecs.push_back(mk(S0,   5'b00100, 32'h0, 32'h400, 32'h12345678, 4'b0000, 4'h0, 32'h0,   2'd2, 32'hCAFEF00D));
        vecs.push_back(mk(S0,   5'b00000, 32'h0, 32'h400, 32'h0,        4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Flush mid-cycle: drained ack discarded, then a fresh grant completes
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b10100, 32'h0, 32'h500, 32'h0,        4'b1001, 4'h3, 32'h500, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b1001, 4'h3, 32'h500, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00101, 32'h0, 32'h500, 32'h77778888, 4'b1001, 4'h3, 32'h500, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b1001, 4'h3, 32'h500, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00101, 32'h0, 32'h500, 32'h9999AAAA, 4'b1000, 4'h3, 32'h500, 2'd2, 32'h9999AAAA));
        vecs.push_back(mk(S0, 5'b00000, 32'h0, 32'h0, 32'h0,          4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Flush in IDLE blocks that cycle's grant
        vecs.push_back(mk(S0, 5'b10100, 32'h0, 32'h500, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00100, 32'h0, 32'h500, 32'h0,        4'b1001, 4'h3, 32'h500, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00101, 32'h0, 32'h500, 32'h00000001, 4'b1000, 4'h3, 32'h500, 2'd2, 32'h00000001));
        vecs.push_back(mk(S0, 5'b00000, 32'h0, 32'h0, 32'h0,          4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));
        // Store
        vecs.push_back(mk(S0, 5'b00110, 32'h0, 32'h600, 32'h0,        4'b0001, 4'h0, 32'h0,   2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00110, 32'h0, 32'h600, 32'h0,        4'b1101, 4'h3, 32'h600, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00111, 32'h0, 32'h600, 32'h0,        4'b1100, 4'h3, 32'h600, 2'd0, 32'h0));
        vecs.push_back(mk(S0, 5'b00000, 32'h0, 32'h600, 32'h0,        4'b0000, 4'h0, 32'h0,   2'd0, 32'h0));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_stb", 32'(wb_stb_o), 32'h0);
        check("rst_we", 32'(wb_we_o), 32'h0);
        check("rst_sel", 32'(wb_sel_o), 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("v%0d_cyc", i), 32'(wb_cyc_o), 32'(vecs[i].ex[3]));
            check($sformatf("v%0d_stb", i), 32'(wb_stb_o), 32'(vecs[i].ex[3]));
            check($sformatf("v%0d_sreq_if", i), 32'(stallreq_if), 32'(vecs[i].ex[1]));
            check($sformatf("v%0d_sreq_mem", i), 32'(stallreq_mem), 32'(vecs[i].ex[0]));
            if (vecs[i].ex[3]) begin
                check($sformatf("v%0d_we", i), 32'(wb_we_o), 32'(vecs[i].ex[2]));
                check($sformatf("v%0d_sel", i), 32'(wb_sel_o), 32'(vecs[i].esel));
                check($sformatf("v%0d_adr", i), wb_adr_o, vecs[i].eadr);
                if (vecs[i].ex[2]) check($sformatf("v%0d_wdat", i), wb_dat_o, MEM_WDATA);
            end
            if (vecs[i].rc == 2'd1) check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].erd);
            if (vecs[i].rc == 2'd2) check($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].erd);
        end

        // Starvation: both held, slave acks at once; every 5th grant goes to IF
        for (int g = 0; g < 10; g++) exp_q.push_back((g % 5 == 4) ? 32'h800 : 32'h700);
        stall = S0; flush = 1'b0; mem_we = 1'b0;
        mem_ce = 1'b1; if_ce = 1'b1; mem_addr = 32'h700; if_addr = 32'h800;
        grants = 0;
        cycles = 0;
        while (grants < 10 && cycles < 60) begin
            @(negedge clk);
            wb_ack_i = wb_cyc_o;
            wb_dat_i = 32'h0;
            #1;
            if (wb_cyc_o) begin
                check($sformatf("starve_grant%0d", grants), wb_adr_o, exp_q.pop_front());
                grants++;
            end
            cycles++;
        end
        if (grants < 10) check("starve_budget", 32'(grants), 32'd10);
        @(negedge clk);
        mem_ce = 1'b0; if_ce = 1'b0; wb_ack_i = 1'b0;
        #1;
        check("starve_end_cyc", 32'(wb_cyc_o), 32'h0);

        // Timeout: slave never acks
        @(negedge clk);
        mem_ce = 1'b1; mem_addr = 32'h900;
        cnt = 0;
        cycles = 0;
        seen_end = 1'b0;
        while (!seen_end && cycles < 400) begin
            @(negedge clk);
            #1;
            cycles++;
            if (wb_cyc_o) begin
                cnt++;
                if (cnt == TIMEOUT - 1) check("tmo_pre_sreq", 32'(stallreq_mem), 32'h1);
                if (cnt == TIMEOUT) begin
                    check("tmo_sreq", 32'(stallreq_mem), 32'h0);
                    check("tmo_rdata", mem_rdata, 32'h0);
                    mem_ce = 1'b0;
                end
            end else if (cnt > 0) begin
                seen_end = 1'b1;
            end
        end
        check("tmo_len", 32'(cnt), 32'(TIMEOUT));
        check("tmo_bus_err", 32'(bus_err_o), 32'h1);
        check("tmo_state", 32'(dbg_state_o), 32'h0);
        @(negedge clk);
        #1;
        check("tmo_bus_err_pulse", 32'(bus_err_o), 32'h0);
        check("tmo_idle_cyc", 32'(wb_cyc_o), 32'h0);

        // Reset mid-cycle drops cyc on the next edge
        mem_ce = 1'b1; mem_addr = 32'hA00;
        cycles = 0;
        do begin
            @(negedge clk);
            #1;
            cycles++;
        end while (!wb_cyc_o && cycles < 5);
        check("mid_rst_cyc_before", 32'(wb_cyc_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("mid_rst_adr", wb_adr_o, 32'h0);
        check("mid_rst_state", 32'(dbg_state_o), 32'h0);
        rst = 1'b0;
        mem_ce = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
